// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive-side FIFO for a UART. Stores {error, byte} entries
//                from the receiver and presents the head entry to the register
//                interface in first-word-fall-through form. It also provides a
//                sticky overrun flag and a level-threshold interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          wr_tick,
    input  logic [7:0]    wr_data,
    input  logic          wr_err,
    input  logic          rd_en,
    input  logic          clr,
    input  logic          ovr_clr,
    input  logic [AW:0]   thresh,
    output logic [7:0]    rd_data,
    output logic          rd_err,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overrun,
    output logic          thresh_irq
);

    localparam logic [AW-1:0] c_ptr_one = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   c_lvl_one = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);

    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_overrun;

    logic          w_empty;
    logic          w_full;
    logic          w_rd_ok;
    logic          w_wr_ok;
    logic          w_drop;
    logic [8:0]    w_head;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_depth);

    // A pop only happens when something is stored. A write is accepted when
    // there is room, or when the FIFO is full but a pop frees a slot on the
    // same edge. That slot is the head, which is read out before it is overwritten.
    assign w_rd_ok = rd_en && !w_empty;
    assign w_wr_ok = wr_tick && (!w_full || w_rd_ok);
    assign w_drop  = wr_tick && !w_wr_ok;

    // Storage array: intentionally not reset, contents are hidden while empty
    always_ff @(posedge clk) begin
        if (w_wr_ok && !clr) begin
            r_mem[r_wr_ptr] <= {wr_err, wr_data};
        end
    end

    // Pointers, level and sticky overrun; flush takes priority over traffic
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else if (clr) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
            // A drop on the same edge as ovr_clr keeps the flag set
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    // Head entry is forced to zero while empty so stale array data never leaks out
    assign rd_data    = w_empty ? 8'h00 : w_head[7:0];
    assign rd_err     = w_empty ? 1'b0  : w_head[8];
    assign empty      = w_empty;
    assign full       = w_full;
    assign level      = r_level;
    assign overrun    = r_overrun;
    assign thresh_irq = (thresh != '0) && (r_level >= thresh);

endmodule
`default_nettype wire
